tour_solver: RTL and testbench

- Computes a complete knight's tour on the 5x5 board from a commanded start square, using a deterministic depth-first backtracking search.
- Stores the 24 resulting moves as one-hot move codes. The move command sequencer reads them back by index and converts each into vertical and horizontal move commands.
- Sits directly upstream of that sequencer: `done` launches the tour, `move` is read at `indx`.

---
 rtl/tour_solver_if.sv | 20 ++
 rtl/tour_solver.sv | 114 +++++++++++
 tb/tb_tour_solver.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/tour_solver_if.sv
// tour_solver_if: command, status and move read-back bundle between
// the tour sequencer side (master) and tour_solver (slave).
interface tour_solver_if;
   logic       i_go;
   logic [2:0] i_x_start;
   logic [2:0] i_y_start;
   logic [4:0] i_indx;
   logic [7:0] o_move;
   logic       o_done;
   logic       o_no_tour;
   logic       o_busy;
   modport master (
      output i_go, i_x_start, i_y_start, i_indx,
      input  o_move, o_done, o_no_tour, o_busy
   );
   modport slave (
      input  i_go, i_x_start, i_y_start, i_indx,
      output o_move, o_done, o_no_tour, o_busy
   );
endinterface

// File: rtl/tour_solver.sv
// tour_solver: depth-first backtracking knight's tour search on a 5x5 board,
// storing the 24 moves as one-hot codes readable by index.
module tour_solver #(
   parameter int BOARD_DIM = 5,
   parameter int LAST_MV   = 23
) (
   input logic          clk,
   input logic          rst_n,
   tour_solver_if.slave bus
);
   localparam logic [2:0] S_IDLE = 3'd0, S_CALC = 3'd1, S_PICK = 3'd2,
                          S_BACKUP = 3'd3, S_DONE = 3'd4, S_FAIL = 3'd5;
   localparam int NSQ = BOARD_DIM * BOARD_DIM;
   localparam logic signed [3:0] DIM = 4'(BOARD_DIM);
   localparam logic signed [3:0] DX [8] = '{4'sd1, -4'sd1, -4'sd2, -4'sd2, -4'sd1, 4'sd1, 4'sd2, 4'sd2};
   localparam logic signed [3:0] DY [8] = '{4'sd2, 4'sd2, 4'sd1, -4'sd1, -4'sd2, -4'sd2, -4'sd1, 4'sd1};

   function automatic logic [4:0] sq(input logic [2:0] x, input logic [2:0] y);
      return 5'(y) * 5'(BOARD_DIM) + 5'(x);
   endfunction

   logic [2:0]     r_state;
   logic [NSQ-1:0] r_vis;
   logic [7:0]     r_mv   [LAST_MV+1];
   logic [7:0]     r_poss [LAST_MV+1];
   logic [7:0]     r_try;
   logic [2:0]     r_x, r_y;
   logic [4:0]     r_lvl;

   logic [4:0] w_lm1;
   logic [7:0] w_legal, w_cand, w_pick, w_sel;
   logic [2:0] w_dx, w_dy, w_nx, w_ny, w_xs, w_ys;

   for (genvar k = 0; k < 8; k++) begin : g_mv
      logic signed [3:0] w_tx, w_ty;
      assign w_tx = $signed({1'b0, r_x}) + DX[k];
      assign w_ty = $signed({1'b0, r_y}) + DY[k];
      assign w_legal[k] = !w_tx[3] && w_tx < DIM && !w_ty[3] && w_ty < DIM && !r_vis[sq(w_tx[2:0], w_ty[2:0])];
   end

   // Candidates lie strictly above the last tried bit; an empty try pointer opens all moves.
   assign w_cand = r_poss[r_lvl] & ((r_try == 8'd0) ? 8'hFF : ~((r_try << 1) - 8'd1));
   assign w_pick = w_cand & (~w_cand + 8'd1);
   assign w_lm1  = r_lvl - 5'd1;
   assign w_sel  = (r_state == S_PICK) ? w_pick : r_mv[w_lm1];
   assign w_nx   = (r_state == S_PICK) ? r_x + w_dx : r_x - w_dx;
   assign w_ny   = (r_state == S_PICK) ? r_y + w_dy : r_y - w_dy;
   assign w_xs   = (bus.i_x_start > 3'd4) ? bus.i_x_start - 3'd5 : bus.i_x_start;
   assign w_ys   = (bus.i_y_start > 3'd4) ? bus.i_y_start - 3'd5 : bus.i_y_start;

   always_comb begin
      w_dx = 3'd0;
      w_dy = 3'd0;
      for (int k = 0; k < 8; k++) begin
         w_dx = w_sel[k] ? DX[k][2:0] : w_dx;
         w_dy = w_sel[k] ? DY[k][2:0] : w_dy;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_vis   <= '0;
         r_try   <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_lvl   <= '0;
         for (int i = 0; i <= LAST_MV; i++) begin
            r_mv[i]   <= '0;
            r_poss[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: if (bus.i_go) begin
               r_vis <= NSQ'(1) << sq(w_xs, w_ys);
               for (int i = 0; i <= LAST_MV; i++) r_mv[i] <= '0;
               r_x     <= w_xs;
               r_y     <= w_ys;
               r_lvl   <= '0;
               r_state <= S_CALC;
            end
            S_CALC: begin
               r_poss[r_lvl] <= w_legal;
               r_try         <= '0;
               r_state       <= S_PICK;
            end
            S_PICK: if (w_pick != 8'd0) begin
               r_mv[r_lvl]         <= w_pick;
               r_x                 <= w_nx;
               r_y                 <= w_ny;
               r_vis[sq(w_nx, w_ny)] <= 1'b1;
               r_lvl               <= r_lvl + 5'd1;
               r_state             <= (r_lvl == 5'(LAST_MV)) ? S_DONE : S_CALC;
            end else begin
               r_state <= (r_lvl == 5'd0) ? S_FAIL : S_BACKUP;
            end
            S_BACKUP: begin
               r_vis[sq(r_x, r_y)] <= 1'b0;
               r_lvl   <= w_lm1;
               r_x     <= w_nx;
               r_y     <= w_ny;
               r_try   <= r_mv[w_lm1];
               r_state <= S_PICK;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_busy    = r_state != S_IDLE;
   assign bus.o_done    = r_state == S_DONE;
   assign bus.o_no_tour = r_state == S_FAIL;
   assign bus.o_move    = (bus.i_indx <= 5'(LAST_MV)) ? r_mv[bus.i_indx] : 8'h00;
endmodule

// File: tb/tb_tour_solver.sv
// tb_tour_solver: vector table of searches with a scoreboard of expected
// outcomes, plus tour replay, rerun determinism and mid-search reset.
module tb_tour_solver;
   localparam int BUDGET = 100_000_000;

   typedef struct {
      logic [2:0] x;
      logic [2:0] y;
      bit         tour;
      bit         glitch;
      int         save;
      int         cmp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   bit   exp_q[$];
   logic [7:0] tbl [24];
   logic [7:0] ref_tbl [2][24];
   int   ref_lat [2];
   vec_t vecs [5];
   int   lat;

   tour_solver_if bus();
   tour_solver #(.BOARD_DIM(5), .LAST_MV(23)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run(input logic [2:0] x, input logic [2:0] y, input bit tour, input bit glitch, output int n_lat);
      bit exp;
      int n;
      exp_q.push_back(tour);
      @(negedge clk);
      bus.i_go = 1'b1;
      bus.i_x_start = x;
      bus.i_y_start = y;
      @(negedge clk);
      bus.i_go = 1'b0;
      check("busy_rise", 32'(bus.o_busy), 32'd1);
      n_lat = 1;
      while (!(bus.o_done || bus.o_no_tour) && n_lat < BUDGET) begin
         if (glitch) begin
            bus.i_go = (n_lat == 10);
            bus.i_x_start = 3'd4;
            bus.i_y_start = 3'd4;
         end
         @(negedge clk);
         n_lat++;
      end
      bus.i_go = 1'b0;
      exp = exp_q.pop_front();
      if (n_lat >= BUDGET) begin
         check("timeout", 32'(n_lat), 32'(BUDGET - 1));
         return;
      end
      check("outcome", 32'({bus.o_done, bus.o_no_tour}), exp ? 32'd2 : 32'd1);
      check("busy_at_end", 32'(bus.o_busy), 32'd1);
      n = 0;
      repeat (4) begin
         @(negedge clk);
         n += int'(bus.o_done) + int'(bus.o_no_tour);
      end
      check("extra_pulse", 32'(n), 32'd0);
      check("busy_fall", 32'(bus.o_busy), 32'd0);
   endtask

   task automatic replay(input logic [2:0] sx, input logic [2:0] sy);
      logic [24:0] vis;
      logic [7:0]  m;
      int cx, cy, dx, dy;
      bit ok;
      cx = int'(sx);
      cy = int'(sy);
      vis = 25'(1) << (cy * 5 + cx);
      for (int i = 0; i < 24; i++) begin
         bus.i_indx = 5'(i);
         #1;
         m = bus.o_move;
         tbl[i] = m;
         check("onehot", 32'($onehot(m)), 32'd1);
         case (m)
            8'h01:   begin dx =  1; dy =  2; end
            8'h02:   begin dx = -1; dy =  2; end
            8'h04:   begin dx = -2; dy =  1; end
            8'h08:   begin dx = -2; dy = -1; end
            8'h10:   begin dx = -1; dy = -2; end
            8'h20:   begin dx =  1; dy = -2; end
            8'h40:   begin dx =  2; dy = -1; end
            8'h80:   begin dx =  2; dy =  1; end
            default: begin dx =  0; dy =  0; end
         endcase
         cx += dx;
         cy += dy;
         ok = cx >= 0 && cx < 5 && cy >= 0 && cy < 5 && !vis[cy * 5 + cx];
         check("legal", 32'(ok), 32'd1);
         if (ok) vis[cy * 5 + cx] = 1'b1;
      end
      check("cover", 32'(vis), 32'h1FF_FFFF);
   endtask

   task automatic cmp_ref(input int slot, input int n_lat);
      for (int i = 0; i < 24; i++) check("rerun_tbl", 32'(tbl[i]), 32'(ref_tbl[slot][i]));
      check("rerun_lat", 32'(n_lat), 32'(ref_lat[slot]));
   endtask

   initial begin
      vecs[0] = '{x: 3'd2, y: 3'd2, tour: 1'b1, glitch: 1'b0, save: 0,  cmp: -1};
      vecs[1] = '{x: 3'd0, y: 3'd0, tour: 1'b1, glitch: 1'b0, save: 1,  cmp: -1};
      vecs[2] = '{x: 3'd0, y: 3'd0, tour: 1'b1, glitch: 1'b0, save: -1, cmp: 1};
      vecs[3] = '{x: 3'd0, y: 3'd1, tour: 1'b0, glitch: 1'b0, save: -1, cmp: -1};
      vecs[4] = '{x: 3'd2, y: 3'd2, tour: 1'b1, glitch: 1'b1, save: -1, cmp: 0};
      bus.i_go = 1'b0;
      bus.i_x_start = 3'd0;
      bus.i_y_start = 3'd0;
      bus.i_indx = 5'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_busy", 32'(bus.o_busy), 32'd0);
      check("reset_done", 32'(bus.o_done), 32'd0);
      check("reset_no_tour", 32'(bus.o_no_tour), 32'd0);
      for (int i = 0; i < 32; i++) begin
         bus.i_indx = 5'(i);
         #1;
         check("reset_move", 32'(bus.o_move), 32'd0);
      end
      foreach (vecs[v]) begin
         run(vecs[v].x, vecs[v].y, vecs[v].tour, vecs[v].glitch, lat);
         if (vecs[v].tour) replay(vecs[v].x, vecs[v].y);
         if (vecs[v].save >= 0) begin
            for (int i = 0; i < 24; i++) ref_tbl[vecs[v].save][i] = tbl[i];
            ref_lat[vecs[v].save] = lat;
         end
         if (vecs[v].cmp >= 0) cmp_ref(vecs[v].cmp, lat);
      end
      // Reset in the middle of a (2,2) search, then a clean (2,2) run.
      @(negedge clk);
      bus.i_go = 1'b1;
      bus.i_x_start = 3'd2;
      bus.i_y_start = 3'd2;
      @(negedge clk);
      bus.i_go = 1'b0;
      repeat (30) @(negedge clk);
      bus.i_indx = 5'd0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.o_busy), 32'd0);
      check("rst_move", 32'(bus.o_move), 32'd0);
      check("rst_done", 32'(bus.o_done), 32'd0);
      check("rst_no_tour", 32'(bus.o_no_tour), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run(3'd2, 3'd2, 1'b1, 1'b0, lat);
      replay(3'd2, 3'd2);
      cmp_ref(0, lat);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
